// File: rtl/dual_port_ram_pkg.sv
// Shared constants for the dual-port RAM: default geometry and the policy
// applied when both ports write the same word in the same cycle.
package dual_port_ram_pkg;

   localparam int DPRAM_DATA_DEFAULT = 64;
   localparam int DPRAM_ADDR_DEFAULT = 10;

   // When both ports write one address together, port A's data is kept.
   localparam bit PORT_A_WINS = 1'b1;

endpackage

// File: rtl/dual_port_ram_outstage.sv
// Output pipeline for one RAM port: one register stage, or two when
// DUAL_PORT_RAM_OUTREG_EN is defined. Both stages clear on synchronous reset.
module dual_port_ram_outstage #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   logic [WIDTH-1:0] stage1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1_q <= '0;
      end else begin
         stage1_q <= data_i;
      end
   end

`ifdef DUAL_PORT_RAM_OUTREG_EN
   logic [WIDTH-1:0] stage2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage2_q <= '0;
      end else begin
         stage2_q <= stage1_q;
      end
   end

   assign data_o = stage2_q;
`else
   assign data_o = stage1_q;
`endif

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port read-first RAM on one clock. Define DUAL_PORT_RAM_OUTREG_EN
// to add a second output register stage (read latency 2 instead of 1).
module dual_port_ram
   import dual_port_ram_pkg::*;
#(
   parameter int DATA = DPRAM_DATA_DEFAULT,
   parameter int ADDR = DPRAM_ADDR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wea,
   input  logic [ADDR-1:0] addra,
   input  logic [DATA-1:0] dina,
   output logic [DATA-1:0] douta,
   input  logic            web,
   input  logic [ADDR-1:0] addrb,
   input  logic [DATA-1:0] dinb,
   output logic [DATA-1:0] doutb,
   output logic            collision
);

   localparam int DEPTH = 2 ** ADDR;

   logic [DATA-1:0] mem_q [DEPTH];
   logic [DATA-1:0] readA_d;
   logic [DATA-1:0] readB_d;
   logic            collision_d;

   // Reads sample the array before this edge's writes land, giving read-first.
   assign readA_d     = mem_q[addra];
   assign readB_d     = mem_q[addrb];
   assign collision_d = wea & web & (addra == addrb);

   // No reset on storage so the array maps to block RAM; the later
   // non-blocking write wins a same-address conflict.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (PORT_A_WINS) begin
            if (web) mem_q[addrb] <= dinb;
            if (wea) mem_q[addra] <= dina;
         end else begin
            if (wea) mem_q[addra] <= dina;
            if (web) mem_q[addrb] <= dinb;
         end
      end
   end

   dual_port_ram_outstage #(.WIDTH(DATA)) outA (
      .clk    (clk),
      .rst    (rst),
      .data_i (readA_d),
      .data_o (douta)
   );

   dual_port_ram_outstage #(.WIDTH(DATA)) outB (
      .clk    (clk),
      .rst    (rst),
      .data_i (readB_d),
      .data_o (doutb)
   );

   dual_port_ram_outstage #(.WIDTH(1)) outCollision (
      .clk    (clk),
      .rst    (rst),
      .data_i (collision_d),
      .data_o (collision)
   );

endmodule

// File: tb/tb_dual_port_ram.sv
// Directed, table-driven bench for dual_port_ram (DATA=16, ADDR=4), with
// hand-written reset and back-to-back collision sequences.
module tb_dual_port_ram;

   localparam int DATA = 16;
   localparam int ADDR = 4;
`ifdef DUAL_PORT_RAM_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            wea;
   logic [ADDR-1:0] addra;
   logic [DATA-1:0] dina;
   logic [DATA-1:0] douta;
   logic            web;
   logic [ADDR-1:0] addrb;
   logic [DATA-1:0] dinb;
   logic [DATA-1:0] doutb;
   logic            collision;

   typedef struct {
      logic            weA;
      logic [ADDR-1:0] addrA;
      logic [DATA-1:0] dinA;
      logic            weB;
      logic [ADDR-1:0] addrB;
      logic [DATA-1:0] dinB;
      logic            chkA;
      logic [DATA-1:0] expA;
      logic            chkB;
      logic [DATA-1:0] expB;
      logic            expCol;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   logic opWeA [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic opWeB [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   logic [ADDR-1:0] opAddrA [5] = '{4'd14, 4'd14, 4'd15, 4'd15, 4'd0};
   logic [ADDR-1:0] opAddrB [5] = '{4'd14, 4'd15, 4'd15, 4'd15, 4'd0};
   logic expColSeq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   dual_port_ram #(.DATA(DATA), .ADDR(ADDR)) dut (
      .clk       (clk),
      .rst       (rst),
      .wea       (wea),
      .addra     (addra),
      .dina      (dina),
      .douta     (douta),
      .web       (web),
      .addrb     (addrb),
      .dinb      (dinb),
      .doutb     (doutb),
      .collision (collision)
   );

   always #5 clk = ~clk;

   function automatic vec_t mkVec(input logic wa, input logic [ADDR-1:0] aa, input logic [DATA-1:0] da,
                                  input logic wb, input logic [ADDR-1:0] ab, input logic [DATA-1:0] db,
                                  input logic ca, input logic [DATA-1:0] ea,
                                  input logic cb, input logic [DATA-1:0] eb, input logic col);
      vec_t v;
      v.weA = wa; v.addrA = aa; v.dinA = da;
      v.weB = wb; v.addrB = ab; v.dinB = db;
      v.chkA = ca; v.expA = ea; v.chkB = cb; v.expB = eb; v.expCol = col;
      return v;
   endfunction

   // Issue one operation, then idle until its result reaches the outputs.
   task automatic applyStimulus(input vec_t v);
      wea = v.weA; addra = v.addrA; dina = v.dinA;
      web = v.weB; addrb = v.addrB; dinb = v.dinB;
      @(posedge clk); #1;
      wea = 1'b0; web = 1'b0;
      for (int i = 1; i < LAT; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic checkOutput(input string name, input logic [DATA-1:0] act, input logic [DATA-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic runVec(input vec_t v, input string tag);
      applyStimulus(v);
      if (v.chkA) checkOutput({tag, " douta"}, douta, v.expA);
      if (v.chkB) checkOutput({tag, " doutb"}, doutb, v.expB);
      checkOutput({tag, " collision"}, {{(DATA-1){1'b0}}, collision}, {{(DATA-1){1'b0}}, v.expCol});
   endtask

   task automatic resetWithWrite(input logic [DATA-1:0] junk, input string tag);
      rst = 1'b1;
      wea = 1'b1; addra = 4'd5; dina = junk;
      web = 1'b0; addrb = ADDR'($urandom_range(0, 15)); dinb = DATA'($urandom);
      repeat (2) begin
         @(posedge clk); #1;
         addrb = ADDR'($urandom_range(0, 15));
      end
      checkOutput({tag, " douta"}, douta, '0);
      checkOutput({tag, " doutb"}, doutb, '0);
      checkOutput({tag, " collision"}, {{(DATA-1){1'b0}}, collision}, '0);
      rst = 1'b0; wea = 1'b0;
   endtask

   initial begin
      // Directed table: expected values worked out by hand from read-first rules.
      vecs.push_back(mkVec(1, 3, 16'h1234, 0, 0, 0,       0, 0,       0, 0,       0));
      vecs.push_back(mkVec(0, 3, 0,        0, 3, 0,       1, 16'h1234, 1, 16'h1234, 0));
      vecs.push_back(mkVec(1, 7, 16'h0011, 0, 3, 0,       0, 0,       1, 16'h1234, 0));
      vecs.push_back(mkVec(1, 7, 16'h0022, 0, 7, 0,       1, 16'h0011, 1, 16'h0011, 0));
      vecs.push_back(mkVec(0, 7, 0,        0, 7, 0,       1, 16'h0022, 1, 16'h0022, 0));
      vecs.push_back(mkVec(0, 3, 0,        1, 9, 16'h0005, 1, 16'h1234, 0, 0,       0));
      vecs.push_back(mkVec(1, 9, 16'h0006, 0, 9, 0,       1, 16'h0005, 1, 16'h0005, 0));
      vecs.push_back(mkVec(0, 9, 0,        0, 9, 0,       1, 16'h0006, 1, 16'h0006, 0));
      vecs.push_back(mkVec(1, 13, 16'h0099, 1, 12, 16'h0077, 0, 0,     0, 0,       0));
      vecs.push_back(mkVec(1, 12, 16'h00A0, 1, 12, 16'h00B0, 1, 16'h0077, 1, 16'h0077, 1));
      vecs.push_back(mkVec(0, 12, 0,       0, 13, 0,      1, 16'h00A0, 1, 16'h0099, 0));
      vecs.push_back(mkVec(1, 13, 16'h0001, 0, 12, 0,     1, 16'h0099, 1, 16'h00A0, 0));
      vecs.push_back(mkVec(0, 13, 0,       1, 13, 16'h0002, 1, 16'h0001, 1, 16'h0001, 0));
      vecs.push_back(mkVec(0, 13, 0,       0, 13, 0,      1, 16'h0002, 1, 16'h0002, 0));

      wea = 1'b0; web = 1'b0; addra = '0; addrb = '0; dina = '0; dinb = '0; rst = 1'b1;

      resetWithWrite(16'h00AA, "reset1");
      runVec(mkVec(1, 5, 16'h0055, 0, 0, 0, 0, 0, 0, 0, 0), "preload5");
      runVec(mkVec(0, 5, 0, 0, 5, 0, 1, 16'h0055, 1, 16'h0055, 0), "read5");
      resetWithWrite(16'h00AA, "reset2");
      runVec(mkVec(0, 5, 0, 0, 5, 0, 1, 16'h0055, 1, 16'h0055, 0), "reset_write_ignored");

      for (int i = 0; i < vecs.size(); i++) begin
         runVec(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back dual writes: collision must follow each cycle exactly.
      for (int k = 0; k < 5 + LAT - 1; k++) begin
         if (k < 5) begin
            wea = opWeA[k]; addra = opAddrA[k]; dina = DATA'(k);
            web = opWeB[k]; addrb = opAddrB[k]; dinb = DATA'(k + 16);
         end else begin
            wea = 1'b0; web = 1'b0;
         end
         @(posedge clk); #1;
         if (k >= LAT - 1) begin
            checkOutput($sformatf("stream_collision%0d", k - LAT + 1),
                        {{(DATA-1){1'b0}}, collision}, {{(DATA-1){1'b0}}, expColSeq[k - LAT + 1]});
         end
      end
      wea = 1'b0; web = 1'b0;

      // Full sweep: fill through A, read back through B forwards and reversed.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(mkVec(1, ADDR'(i), DATA'(i * 3), 0, 0, 0, 0, 0, 0, 0, 0));
      end
      for (int i = 0; i < 16; i++) begin
         runVec(mkVec(0, ADDR'(15 - i), 0, 0, ADDR'(i), 0, 1, DATA'((15 - i) * 3), 1, DATA'(i * 3), 0),
                $sformatf("sweep_fwd%0d", i));
      end
      for (int i = 15; i >= 0; i--) begin
         runVec(mkVec(0, 0, 0, 0, ADDR'(i), 0, 0, 0, 1, DATA'(i * 3), 0), $sformatf("sweep_rev%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dual_port_ram.md
Name: dual_port_ram

Overview:
- True dual-port synchronous RAM with two independent read/write ports, A and B, on a single clock.
- Storage backend for the dual-port synchronous FIFO and similar buffers.
- Each port writes or reads one word per cycle.
- Registered read data; behaviour on simultaneous same-address accesses is fully defined.

Parameters:
- DATA, default 64: word width in bits (≥1).
- ADDR, default 10: address width in bits; depth = 2**ADDR words (≥1).

Ports:
- clk, input, 1: single clock for both ports; all state changes on the rising edge.
- rst, input, 1: synchronous active-high reset.
- wea, input, 1: port A write enable; when low, port A performs a read.
- addra, input, ADDR: port A address.
- dina, input, DATA: port A write data.
- douta, output, DATA: port A read data (registered).
- web, input, 1: port B write enable; when low, port B performs a read.
- addrb, input, ADDR: port B address.
- dinb, input, DATA: port B write data.
- doutb, output, DATA: port B read data (registered).
- collision, output, 1: registered flag; both ports wrote the same address in the previous cycle.

Behaviour:
- Reset: when rst=1 at a rising edge, douta=0, doutb=0 and collision=0 on the next cycle.
  - Memory array contents are not cleared by reset.
  - Writes presented during a reset cycle are ignored, so memory is unchanged.
- Power-up memory contents are undefined. The array must be inferable as block RAM: no reset on storage, no per-word initialisation logic.
- Write: wea=1 at an edge stores dina to mem[addra]. Same rule for web, dinb, addrb.
- Read latency is 1 cycle.
  - Each edge with rst=0, douta <= mem[addra] and doutb <= mem[addrb], whether or not that port is writing.
  - Outputs change only at clock edges and hold between edges.
- Read-during-write, same port: read-first. dout shows the word's value before that edge's write.
- Cross-port, same address, one port writes and the other reads: read-first. The reader gets the old value; the new value is visible one read later.
- Both ports write the same address in the same cycle:
  - Port A wins, so mem[addr] = dina.
  - Both douta and doutb show the old value (read-first).
  - collision=1 for exactly the following cycle.
- Both ports write different addresses: both writes take effect and collision=0.
- Both ports read the same address: both get the same data; no conflict.
- collision is recomputed every cycle: collision <= wea & web & (addra==addrb). It is 0 in the cycle after reset.
- Addresses wrap naturally; all 2**ADDR locations are valid and there is no out-of-range case.

Optional Feature:
- Macro: DUAL_PORT_RAM_OUTREG_EN.
- When defined:
  - An extra output pipeline register is added on douta, doutb and collision, so read latency becomes 2 cycles.
  - rst clears both register stages to 0.
  - Read-first and collision semantics are unchanged, only delayed by one cycle.
- When undefined: 1-cycle latency as specified above.

Decomposition:
- Shared package dual_port_ram_pkg holds:
  - default constants DPRAM_DATA_DEFAULT=64 and DPRAM_ADDR_DEFAULT=10;
  - a localparam documenting the collision policy (PORT_A_WINS=1).
- Sub-module dual_port_ram_outstage: per-port output pipeline (1 or 2 register stages with sync reset). Instantiated twice for ports A and B; collision gets its own matching delay.
- Storage array and write arbitration stay in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random addresses -> douta=0, doutb=0, collision=0. Write via A during reset (addra=5, dina=0xAA) -> after reset, reading addr 5 is not 0xAA.
- Basic write/read: A writes addr 3 = 0x1234, then B reads addr 3 -> doutb=0x1234 one cycle after the read edge (two cycles with DUAL_PORT_RAM_OUTREG_EN).
- Read-first, same port: mem[7]=0x11; A writes 0x22 to addr 7 -> douta=0x11 next cycle. A then reads addr 7 -> douta=0x22.
- Cross-port same address: mem[9]=0x5; A writes 0x6 to addr 9 while B reads addr 9 -> doutb=0x5. B reads again -> doutb=0x6.
- Dual-write collision: A writes 0xA0 and B writes 0xB0 to addr 12 in the same cycle -> collision=1 for one cycle, then 0. A later read of addr 12 returns 0xA0.
- Full sweep: ADDR=4; fill via A (mem[i]=i*3), read back via B in the same order and then reversed -> every word matches; addresses 0 and 15 included.
